// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, MDU results
// wait in a small FIFO, and a starvation counter forces a one-cycle drain stall.
module wb_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wb_valid,
    input  logic [ADDR_WIDTH-1:0] pipe_wb_rd,
    input  logic [DATA_WIDTH-1:0] pipe_wb_data,
    output logic                  pipe_stall,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [ADDR_WIDTH-1:0] mdu_rd,
    input  logic [DATA_WIDTH-1:0] mdu_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [PTR_W:0]   DEPTH_C    = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LIMIT_M1_C = CNT_W'(STARVE_LIMIT - 1);

    typedef enum logic {S_NORMAL, S_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;
    logic                  pipe_stall_q, pipe_stall_d;
    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic [ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

    logic                  fifo_empty, fifo_full, push, pop;
    logic                  grant_pipe, grant_fifo;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == DEPTH_C);
    // Acceptance depends only on start-of-cycle occupancy, so a same-cycle pop never frees a slot early.
    assign push       = mdu_valid && !fifo_full;
    assign pop        = grant_fifo;

    assign mdu_ready  = !fifo_full;
    assign pipe_stall = pipe_stall_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        pipe_stall_d = 1'b0;
        grant_pipe   = 1'b0;
        grant_fifo   = 1'b0;
        case (state_q)
            S_NORMAL: begin
                if (pipe_wb_valid) begin
                    grant_pipe = 1'b1;
                end else if (!fifo_empty) begin
                    grant_fifo = 1'b1;
                end
                if (grant_pipe && !fifo_empty) begin
                    if (starve_q == LIMIT_M1_C) begin
                        state_d      = S_DRAIN;
                        starve_d     = '0;
                        pipe_stall_d = 1'b1;
                    end else begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else begin
                    starve_d = '0;
                end
            end
            S_DRAIN: begin
                // The pipeline is stalled and will re-present its entry, so its valid is ignored here.
                grant_fifo = !fifo_empty;
                state_d    = S_NORMAL;
                starve_d   = '0;
            end
            default: begin
                state_d  = S_NORMAL;
                starve_d = '0;
            end
        endcase
    end

    always_comb begin
        grant_rd   = grant_pipe ? pipe_wb_rd   : rd_mem[rd_ptr_q];
        grant_data = grant_pipe ? pipe_wb_data : data_mem[rd_ptr_q];
        rf_we_d    = (grant_pipe || grant_fifo) && (grant_rd != '0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (grant_pipe || grant_fifo) begin
            rf_waddr_d = grant_rd;
            rf_wdata_d = grant_data;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= mdu_rd;
            data_mem[wr_ptr_q] <= mdu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_NORMAL;
            starve_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            pipe_stall_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            pipe_stall_q <= pipe_stall_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: hand-computed expectations, one line per cycle.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(2), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
        .pipe_stall(pipe_stall),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t we=%b waddr=%0d wdata=%h stall=%b ready=%b",
                 $time, rf_we, rf_waddr, rf_wdata, pipe_stall, mdu_ready);
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_wb_valid = v;
        pipe_wb_rd    = rd;
        pipe_wb_data  = d;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v;
        mdu_rd    = rd;
        mdu_data  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        set_pipe(1'b0, 5'd0, 32'h0);
        set_mdu(1'b0, 5'd0, 32'h0);
        #12;
        check("rst_stall", pipe_stall, 0);
        check("rst_we", rf_we, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_ready", mdu_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle: nothing written for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_we", rf_we, 0);
            check("idle_ready", mdu_ready, 1);
            check("idle_stall", pipe_stall, 0);
        end

        // Pipeline only
        set_pipe(1'b1, 5'd7, 32'h1234_5678);
        step();
        check("pipe_we", rf_we, 1);
        check("pipe_waddr", rf_waddr, 7);
        check("pipe_wdata", rf_wdata, 32'h1234_5678);
        set_pipe(1'b0, 5'd0, 32'h0);
        step();
        check("hold_we", rf_we, 0);
        check("hold_waddr", rf_waddr, 7);
        check("hold_wdata", rf_wdata, 32'h1234_5678);
        set_pipe(1'b1, 5'd0, 32'hAAAA_AAAA);
        step();
        check("pipe_rd0_we", rf_we, 0);
        set_pipe(1'b0, 5'd0, 32'h0);

        // MDU result in an idle gap: push, grant, write
        set_mdu(1'b1, 5'd3, 32'hDEAD_BEEF);
        step();
        check("mdu_push_we", rf_we, 0);
        check("mdu_push_ready", mdu_ready, 1);
        set_mdu(1'b0, 5'd0, 32'h0);
        step();
        check("mdu_we", rf_we, 1);
        check("mdu_waddr", rf_waddr, 3);
        check("mdu_wdata", rf_wdata, 32'hDEAD_BEEF);
        step();
        check("mdu_after_we", rf_we, 0);

        // FIFO order with simultaneous push/pop, plus an rd=0 MDU entry
        set_mdu(1'b1, 5'd20, 32'h20);
        step();
        check("ord1_we", rf_we, 0);
        set_mdu(1'b1, 5'd21, 32'h21);
        step();
        check("ord2_waddr", rf_waddr, 20);
        check("ord2_ready", mdu_ready, 1);
        set_mdu(1'b1, 5'd0, 32'hFF);
        step();
        check("ord3_we", rf_we, 1);
        check("ord3_waddr", rf_waddr, 21);
        check("ord3_wdata", rf_wdata, 32'h21);
        set_mdu(1'b0, 5'd0, 32'h0);
        step();
        check("ord4_rd0_we", rf_we, 0);
        check("ord4_ready", mdu_ready, 1);
        step();
        check("ord5_we", rf_we, 0);

        // Starvation: one queued entry vs. continuous pipeline
        set_mdu(1'b1, 5'd9, 32'h9999_9999);
        step();
        check("stv_push_we", rf_we, 0);
        set_mdu(1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_pipe(1'b1, 5'd5, 32'h50 + 32'(k));
            step();
            check("stv_pipe_we", rf_we, 1);
            check("stv_pipe_waddr", rf_waddr, 5);
            check("stv_pipe_wdata", rf_wdata, 32'h50 + 32'(k));
            check("stv_stall", pipe_stall, (k == 3) ? 1 : 0);
        end
        step();
        check("drain_stall", pipe_stall, 0);
        check("drain_we", rf_we, 1);
        check("drain_waddr", rf_waddr, 9);
        check("drain_wdata", rf_wdata, 32'h9999_9999);
        step();
        check("held_we", rf_we, 1);
        check("held_waddr", rf_waddr, 5);
        check("held_wdata", rf_wdata, 32'h53);
        check("held_stall", pipe_stall, 0);
        set_pipe(1'b0, 5'd0, 32'h0);
        step();

        // Full FIFO backpressure under a busy pipeline, then reset in DRAIN
        set_pipe(1'b1, 5'd1, 32'h1111_1111);
        set_mdu(1'b1, 5'd10, 32'hA0);
        step();
        check("full1_ready", mdu_ready, 1);
        check("full1_waddr", rf_waddr, 1);
        set_mdu(1'b1, 5'd11, 32'hA1);
        step();
        check("full2_ready", mdu_ready, 0);
        set_mdu(1'b1, 5'd12, 32'hA2);
        step();
        check("full3_ready", mdu_ready, 0);
        check("full3_stall", pipe_stall, 0);
        step();
        check("full4_ready", mdu_ready, 0);
        check("full4_stall", pipe_stall, 0);
        step();
        check("full5_stall", pipe_stall, 1);
        check("full5_ready", mdu_ready, 0);
        step();
        check("full6_stall", pipe_stall, 0);
        check("full6_waddr", rf_waddr, 10);
        check("full6_wdata", rf_wdata, 32'hA0);
        check("full6_ready", mdu_ready, 1);
        step();
        check("full7_waddr", rf_waddr, 1);
        check("full7_ready", mdu_ready, 0);
        set_mdu(1'b0, 5'd0, 32'h0);
        step();
        check("full8_stall", pipe_stall, 0);
        step();
        check("full9_stall", pipe_stall, 0);
        step();
        check("full10_stall", pipe_stall, 1);

        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_stall", pipe_stall, 0);
        check("mrst_we", rf_we, 0);
        check("mrst_waddr", rf_waddr, 0);
        check("mrst_ready", mdu_ready, 1);
        set_pipe(1'b0, 5'd0, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_rst_we", rf_we, 0);
            check("post_rst_stall", pipe_stall, 0);
        end
        check("post_rst_ready", mdu_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single architectural register-file write port between two sources: the in-order pipeline write-back result and results from the long-latency multiply/divide unit (MDU).
MDU results are queued in a small FIFO. The pipeline has default priority. A starvation counter forces the pipeline to stall so that queued MDU results drain.
The block sits between the write-back stage/MDU outputs and the register-file write port.

Parameters:
DATA_WIDTH, 32, width of write data
ADDR_WIDTH, 5, register index width
FIFO_DEPTH, 2, MDU result queue entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before a forced drain (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_wb_valid  in  1  pipeline write-back result valid this cycle
pipe_wb_rd  in  ADDR_WIDTH  pipeline destination register
pipe_wb_data  in  DATA_WIDTH  pipeline write-back value
pipe_stall  out  1  registered; pipeline must hold its write-back entry and re-present it next cycle
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  FIFO can accept; transfer occurs when mdu_valid && mdu_ready
mdu_rd  in  ADDR_WIDTH  MDU destination register
mdu_data  in  DATA_WIDTH  MDU result
rf_we  out  1  registered register-file write enable
rf_waddr  out  ADDR_WIDTH  registered write address
rf_wdata  out  DATA_WIDTH  registered write data

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FIFO emptied; starvation counter = 0; state = NORMAL.
  - pipe_stall = 0; rf_we = 0; rf_waddr = 0; rf_wdata = 0.
  - mdu_ready = 1 once FIFO empty. A reset mid-operation discards queued MDU results.
- mdu_ready = !full, combinational from the occupancy at cycle start. No push when full, even if a pop occurs in the same cycle.
- Push and pop in the same cycle on a non-full, non-empty FIFO leaves occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: NORMAL, DRAIN.
  - NORMAL:
    - Grant goes to the pipeline if pipe_wb_valid=1; otherwise to the FIFO head if non-empty; otherwise no grant.
    - If the pipeline is granted while the FIFO is non-empty, the counter increments.
    - If the FIFO is granted or is empty, the counter clears.
    - When the counter would reach STARVE_LIMIT, the next state is DRAIN and pipe_stall is set to 1 on the same edge.
  - DRAIN:
    - pipe_stall = 1; the FIFO head is granted unconditionally. pipe_wb_valid is ignored because the pipeline re-presents its entry.
    - Next state is NORMAL with pipe_stall = 0 and counter = 0.
    - Exactly one MDU result drains per DRAIN visit.
- Grant to output timing: registered, 1-cycle latency.
  - rf_we = 1 the cycle after a grant whose rd != 0; rf_waddr/rf_wdata carry the granted rd/data.
  - Grant with rd = 0: the entry is consumed (FIFO pops, or the pipeline result counts as retired), but rf_we = 0.
  - No grant: rf_we = 0, and rf_waddr/rf_wdata hold their previous values.
- An MDU result pushed in cycle N is granted no earlier than cycle N+1 (no FIFO bypass).
- Ordering: the FIFO is strictly first-in, first-out. No WAW between an outstanding MDU rd and a pipeline rd is guaranteed by the hazard unit; this block does no rd comparison.
- At most one register-file write per cycle, always.

Test Plan:
- Reset then idle: no valids for 5 cycles -> rf_we = 0 throughout, mdu_ready = 1, pipe_stall = 0.
- Pipeline only: pipe_wb_valid = 1, rd = 7, data = 0x1234_5678 in cycle 1 -> cycle 2: rf_we = 1, rf_waddr = 7, rf_wdata = 0x1234_5678. A following rd = 0 entry -> rf_we = 0.
- MDU in idle gap: mdu_valid with rd = 3, data = 0xDEAD_BEEF, pipeline idle -> push in cycle N, grant in N+1, rf_we = 1 in N+2 with rd = 3.
- FIFO full backpressure: two MDU pushes while the pipeline is valid every cycle -> mdu_ready = 0 after the second push. A third mdu_valid held stays unaccepted until a pop.
- Starvation (STARVE_LIMIT = 4): FIFO holds 1 entry (rd = 9), pipe_wb_valid = 1 continuously -> 4 pipeline writes, then pipe_stall = 1 for exactly one cycle. Next cycle rf_waddr = 9; counter resets; the held pipeline entry is written the following cycle.
- Reset mid-drain: rst_n asserted during DRAIN with 2 queued entries -> immediately pipe_stall = 0, rf_we = 0, FIFO empty. After release, no stale MDU write ever appears.
